// File: rtl/calc_pkg.sv
// Shared calculator result-interface definitions: field positions, digit type, serializer states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package calc_pkg;

    localparam int MAG_W      = 15;   // magnitude width; bit MAG_W of the result is the sign
    localparam int NUM_DIGITS = 5;    // enough BCD digits for 2^MAG_W-1 = 32767
    localparam int SIGN_BIT   = 15;
    localparam int MAG_MSB    = 14;
    localparam int PTR_W      = 3;    // digit position pointer, covers 0..NUM_DIGITS-1
    localparam int CNT_W      = 4;    // bit counter, covers 0..MAG_W

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        EMIT,
        DONE
    } ser_state_t;

endpackage

// File: rtl/dabble_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5, then shift left pulling in bit_in.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module dabble_step
    import calc_pkg::*;
(
    input  bcd_t [NUM_DIGITS-1:0] bcd_in,
    input  logic                  bit_in,
    output bcd_t [NUM_DIGITS-1:0] bcd_out
);

    logic [NUM_DIGITS*4-1:0] adj_flat;

    // Pre-shift correction so each nibble stays a valid decimal digit after doubling
    always_comb begin
        adj_flat = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            adj_flat[i*4 +: 4] = (bcd_in[i] >= 4'd5) ? (bcd_in[i] + 4'd3) : bcd_in[i];
        end
    end

    // Carry out of the top nibble is dropped: the magnitude range never needs it
    assign bcd_out = {adj_flat[NUM_DIGITS*4-2:0], bit_in};

endmodule

// File: rtl/result_digit_serializer.sv
// Captures a sign-magnitude result, converts it to BCD one bit per cycle, streams digits MSD first.
// Latency: start at edge N -> first digit_valid after edge N+MAG_W+1; one digit per accepted handshake.
// Backpressure: digit outputs hold while digit_ready is low; RESULT_LZ_SUPPRESS_EN skips leading zeros.
module result_digit_serializer
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             RST,
    input  logic             start,
    input  logic [MAG_W:0]   value_in,
    output logic             busy,
    output logic             digit_valid,
    input  logic             digit_ready,
    output logic [3:0]       digit_out,
    output logic [PTR_W-1:0] digit_idx,
    output logic             digit_last,
    output logic             neg,
    output logic             done
);

    ser_state_t              state;
    logic [MAG_W-1:0]        shift_q;
    bcd_t [NUM_DIGITS-1:0]   bcd_q;
    bcd_t [NUM_DIGITS-1:0]   bcd_step;
    logic [CNT_W-1:0]        bit_cnt;
    logic [PTR_W-1:0]        first_ptr;
    logic [PTR_W-1:0]        ptr_dn;

    dabble_step u_step (
        .bcd_in  (bcd_q),
        .bit_in  (shift_q[MAG_W-1]),
        .bcd_out (bcd_step)
    );

    // digit_idx doubles as the emit pointer; this is the next position down
    assign ptr_dn = digit_idx - PTR_W'(1);

`ifdef RESULT_LZ_SUPPRESS_EN
    // Highest nonzero nibble wins; an all-zero result falls back to the units digit
    always_comb begin
        first_ptr = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[i] != 4'd0) begin
                first_ptr = PTR_W'(i);
            end
        end
    end
`else
    assign first_ptr = PTR_W'(NUM_DIGITS - 1);
`endif

    // Capture, convert, emit and done sequencing with all outputs registered
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            shift_q     <= '0;
            bcd_q       <= '0;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            neg         <= 1'b0;
            digit_valid <= 1'b0;
            digit_out   <= '0;
            digit_idx   <= '0;
            digit_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_q <= value_in[MAG_MSB:0];
                        bcd_q   <= '0;
                        bit_cnt <= '0;
                        // negative zero is reported as positive
                        neg     <= value_in[SIGN_BIT] & (|value_in[MAG_MSB:0]);
                        busy    <= 1'b1;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (bit_cnt != CNT_W'(MAG_W)) begin
                        bcd_q   <= bcd_step;
                        shift_q <= {shift_q[MAG_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end else begin
                        // all bits consumed: present the first digit next cycle
                        digit_valid <= 1'b1;
                        digit_out   <= bcd_q[first_ptr];
                        digit_idx   <= first_ptr;
                        digit_last  <= (first_ptr == '0);
                        state       <= EMIT;
                    end
                end
                EMIT: begin
                    if (digit_ready) begin
                        if (digit_last) begin
                            digit_valid <= 1'b0;
                            digit_out   <= '0;
                            digit_idx   <= '0;
                            digit_last  <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            digit_out   <= bcd_q[ptr_dn];
                            digit_idx   <= ptr_dn;
                            digit_last  <= (ptr_dn == '0);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_digit_serializer.sv
// Randomized and directed bench for result_digit_serializer against a divide/modulo digit model.
// Latency: checks first-digit arrival and the done pulse timing.
// Backpressure: drives always-ready, random-ready and a fixed 4-cycle stall.
module tb_result_digit_serializer;
    import calc_pkg::*;

    logic             clk = 1'b0;
    logic             RST;
    logic             start;
    logic [MAG_W:0]   value_in;
    logic             busy;
    logic             digit_valid;
    logic             digit_ready;
    logic [3:0]       digit_out;
    logic [PTR_W-1:0] digit_idx;
    logic             digit_last;
    logic             neg;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_dig[$];
    int exp_idx[$];

    result_digit_serializer dut (
        .clk         (clk),
        .RST         (RST),
        .start       (start),
        .value_in    (value_in),
        .busy        (busy),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .digit_out   (digit_out),
        .digit_idx   (digit_idx),
        .digit_last  (digit_last),
        .neg         (neg),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference digits by decimal arithmetic on the magnitude
    task automatic model(input logic [MAG_W:0] v);
        int m;
        int d[NUM_DIGITS];
        int top;
        exp_dig.delete();
        exp_idx.delete();
        m = int'(v[MAG_MSB:0]);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d[i] = m % 10;
            m = m / 10;
        end
        top = NUM_DIGITS - 1;
`ifdef RESULT_LZ_SUPPRESS_EN
        while (top > 0 && d[top] == 0) top--;
`endif
        for (int i = top; i >= 0; i--) begin
            exp_dig.push_back(d[i]);
            exp_idx.push_back(i);
        end
    endtask

    // mode 0: ready high; 1: random ready; 2: stall 4 cycles on idx 3. poke: start 99 mid-emit.
    task automatic run_value(input logic [MAG_W:0] v, input int mode, input bit poke);
        int  cyc;
        int  guard;
        int  stall_cnt;
        bit  poked;
        bit  held;
        int  h_out;
        int  h_idx;
        int  h_last;
        int  exp_neg;
        model(v);
        exp_neg = (v[SIGN_BIT] && (v[MAG_MSB:0] != 0)) ? 1 : 0;
        @(posedge clk); #1;
        start = 1'b1;
        value_in = v;
        digit_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        value_in = 16'($urandom);
        check("busy_after_capture", busy, 1);
        check("neg_after_capture", neg, exp_neg);
        check("valid_at_capture", digit_valid, 0);
        cyc = 0;
        while (!digit_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("first_valid_latency", cyc, MAG_W + 1);
        guard = 0;
        stall_cnt = 0;
        poked = 1'b0;
        held = 1'b0;
        h_out = 0; h_idx = 0; h_last = 0;
        while (exp_dig.size() > 0 && guard < 300) begin
            case (mode)
                0: digit_ready = 1'b1;
                1: digit_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (digit_valid && digit_idx == 3'd3 && stall_cnt < 4) begin
                        digit_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        digit_ready = 1'b1;
                    end
                end
            endcase
            if (poke && !poked && exp_dig.size() == 3) begin
                start = 1'b1;
                value_in = 16'd99;
                poked = 1'b1;
            end
            @(negedge clk);
            check("valid_in_emit", digit_valid, 1);
            if (held) begin
                check("hold_out", digit_out, h_out);
                check("hold_idx", digit_idx, h_idx);
                check("hold_last", digit_last, h_last);
            end
            if (digit_valid && digit_ready) begin
                check("digit_out", digit_out, exp_dig[0]);
                check("digit_idx", digit_idx, exp_idx[0]);
                check("digit_last", digit_last, (exp_idx[0] == 0) ? 1 : 0);
                void'(exp_dig.pop_front());
                void'(exp_idx.pop_front());
                held = 1'b0;
            end else if (digit_valid) begin
                check("stall_digit", digit_out, exp_dig[0]);
                held = 1'b1;
                h_out = digit_out; h_idx = digit_idx; h_last = digit_last;
            end
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
        end
        check("stream_complete", exp_dig.size(), 0);
        if (mode == 2) check("stall_cycles", stall_cnt, 4);
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 0);
        check("valid_in_done", digit_valid, 0);
        @(posedge clk); #1;
        check("done_cleared", done, 0);
        check("busy_idle", busy, 0);
        check("neg_held", neg, exp_neg);
        digit_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        start = 1'b0;
        value_in = '0;
        digit_ready = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_valid", digit_valid, 0);
        check("rst_done", done, 0);
        check("rst_neg", neg, 0);
        check("rst_digit_out", digit_out, 0);
        check("rst_digit_idx", digit_idx, 0);
        check("rst_digit_last", digit_last, 0);
        @(posedge clk); #1;
        RST = 1'b0;

        run_value(16'h0022, 0, 1'b0);
        run_value(16'h8028, 0, 1'b0);
        run_value(16'h7FFF, 0, 1'b0);
        run_value(16'h8000, 0, 1'b0);
        run_value(16'd12345, 2, 1'b0);
        run_value(16'd12345, 0, 1'b1);

        // Abort mid-conversion, then confirm a clean restart
        @(posedge clk); #1;
        start = 1'b1;
        value_in = 16'h0005;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2 RST = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", digit_valid, 0);
        check("abort_done", done, 0);
        @(posedge clk); #1;
        RST = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_digit", digit_valid, 0);
            check("abort_no_done", done, 0);
        end
        run_value(16'h0005, 0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            run_value(16'($urandom), 1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
